// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the MiniRISC data memory arbiter: FSM states,
// master indices and the round-robin successor helper.
package data_mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] M_CPU   = 2'd0;
  localparam logic [1:0] M_STACK = 2'd1;
  localparam logic [1:0] M_DBG   = 2'd2;
  localparam logic [1:0] M_NONE  = 2'd3;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: searches from rr_ptr+1 (mod 3)
// and returns the first requesting master.
module rr_pick3
  import data_mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr_ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] c0_s, c1_s, c2_s;

  // Priority search in rotated order
  always_comb begin
    c0_s  = rr_next(rr_ptr);
    c1_s  = rr_next(c0_s);
    c2_s  = rr_next(c1_s);
    valid = |req;
    if (req[c0_s]) begin
      idx = c0_s;
    end else if (req[c1_s]) begin
      idx = c1_s;
    end else if (req[c2_s]) begin
      idx = c2_s;
    end else begin
      idx = c0_s;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Three-master arbiter serialising CPU, stack-engine and debug byte accesses
// onto the single data memory port, with locked sequences and timeout abort.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m2_req,
  input  logic              m2_wr,
  input  logic              m2_lock,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [DATA_W-1:0] m2_wdata,
  output logic              m2_gnt,
  output logic [DATA_W-1:0] m2_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  arb_state_e        state_r;
  logic [1:0]        owner_r;
  logic [1:0]        rr_ptr_r;
  logic [7:0]        cnt_r;

  logic              pick_valid_s;
  logic [1:0]        pick_idx_s;
  logic              req_s, wr_s, lock_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              busy_s, ready_s, timeout_s, done_s;
  logic [2:0]        gnt_s;
  logic [DATA_W-1:0] rdata_s;

  rr_pick3 u_pick (
    .req    ({m2_req, m1_req, m0_req}),
    .rr_ptr (rr_ptr_r),
    .valid  (pick_valid_s),
    .idx    (pick_idx_s)
  );

  // Select the current owner's request qualifiers
  always_comb begin
    req_s   = 1'b0;
    wr_s    = 1'b0;
    lock_s  = 1'b0;
    addr_s  = '0;
    wdata_s = '0;
    case (owner_r)
      M_CPU:   begin req_s = m0_req; wr_s = m0_wr; lock_s = m0_lock; addr_s = m0_addr; wdata_s = m0_wdata; end
      M_STACK: begin req_s = m1_req; wr_s = m1_wr; lock_s = m1_lock; addr_s = m1_addr; wdata_s = m1_wdata; end
      M_DBG:   begin req_s = m2_req; wr_s = m2_wr; lock_s = m2_lock; addr_s = m2_addr; wdata_s = m2_wdata; end
      default: begin req_s = 1'b0; end
    endcase
  end

  // mem_ready beats the timeout when both land in the same cycle
  assign busy_s    = (state_r == ARB_BUSY);
  assign ready_s   = busy_s & req_s & mem_ready;
  assign timeout_s = busy_s & req_s & ~mem_ready & (cnt_r == TO_LAST);
  assign done_s    = ready_s | timeout_s;

  assign mem_wr    = busy_s & req_s & wr_s & ~timeout_s;
  assign mem_rd    = busy_s & req_s & ~wr_s & ~timeout_s;
  assign mem_addr  = busy_s ? addr_s : '0;
  assign mem_wdata = busy_s ? wdata_s : '0;
  assign bus_err   = timeout_s;
  assign rdata_s   = timeout_s ? {DATA_W{1'b1}} : mem_rdata;

  // One-hot completion pulse to the owner only
  always_comb begin
    gnt_s = 3'b000;
    if (done_s && (owner_r != M_NONE)) begin
      gnt_s[owner_r] = 1'b1;
    end else begin
      gnt_s = 3'b000;
    end
  end

  assign m0_gnt   = gnt_s[0];
  assign m1_gnt   = gnt_s[1];
  assign m2_gnt   = gnt_s[2];
  assign m0_rdata = gnt_s[0] ? rdata_s : '0;
  assign m1_rdata = gnt_s[1] ? rdata_s : '0;
  assign m2_rdata = gnt_s[2] ? rdata_s : '0;

  // Arbitration FSM: ownership, round-robin pointer and wait-state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ARB_IDLE;
      owner_r  <= M_NONE;
      rr_ptr_r <= M_DBG;
      cnt_r    <= 8'd0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          cnt_r <= 8'd0;
          if (pick_valid_s) begin
            state_r <= ARB_BUSY;
            owner_r <= pick_idx_s;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          if (!req_s) begin
            state_r <= ARB_IDLE;
            owner_r <= M_NONE;
            cnt_r   <= 8'd0;
          end else if (mem_ready) begin
            rr_ptr_r <= owner_r;
            cnt_r    <= 8'd0;
            if (lock_s) begin
              state_r <= ARB_BUSY;
            end else begin
              state_r <= ARB_IDLE;
              owner_r <= M_NONE;
            end
          end else if (timeout_s) begin
            rr_ptr_r <= owner_r;
            state_r  <= ARB_IDLE;
            owner_r  <= M_NONE;
            cnt_r    <= 8'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          owner_r <= M_NONE;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: inputs change 1 time unit after the
// rising edge, outputs are compared 2 units later.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_wr, m0_lock, m0_gnt;
  logic [7:0] m0_addr, m0_wdata, m0_rdata;
  logic       m1_req, m1_wr, m1_lock, m1_gnt;
  logic [7:0] m1_addr, m1_wdata, m1_rdata;
  logic       m2_req, m2_wr, m2_lock, m2_gnt;
  logic [7:0] m2_addr, m2_wdata, m2_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_wr, mem_rd, mem_ready, bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .m2_req(m2_req), .m2_wr(m2_wr), .m2_lock(m2_lock), .m2_addr(m2_addr),
    .m2_wdata(m2_wdata), .m2_gnt(m2_gnt), .m2_rdata(m2_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  function automatic logic [2:0] gnts();
    return {m2_gnt, m1_gnt, m0_gnt};
  endfunction

  initial begin
    logic [2:0] exp_g;
    rst_n = 1'b0;
    {m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock, m2_req, m2_wr, m2_lock} = 9'd0;
    m0_addr = 8'h00; m0_wdata = 8'h00; m1_addr = 8'h00; m1_wdata = 8'h00;
    m2_addr = 8'h00; m2_wdata = 8'h00;
    mem_rdata = 8'hC3; mem_ready = 1'b1;
    repeat (2) next();
    look();
    chk("rst_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
    chk("rst_addr_wdata", {16'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_gnt_err", {28'd0, gnts(), bus_err}, 32'd0);
    chk("rst_rdata", {8'd0, m0_rdata, m1_rdata, m2_rdata}, 32'd0);

    // Single read by m0
    next(); rst_n = 1'b1; m0_req = 1'b1; m0_addr = 8'h10; m0_wr = 1'b0; look();
    chk("rd_idle_strobe", {31'd0, mem_rd}, 32'd0);
    chk("rd_idle_gnt", {29'd0, gnts()}, 32'd0);
    next(); mem_rdata = 8'hA5; look();
    chk("rd_busy_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("rd_busy_addr", {24'd0, mem_addr}, 32'h10);
    chk("rd_gnt", {29'd0, gnts()}, 32'b001);
    chk("rd_rdata", {24'd0, m0_rdata}, 32'hA5);
    chk("rd_other_rdata", {16'd0, m1_rdata, m2_rdata}, 32'd0);
    next(); m0_req = 1'b0; look();
    chk("rd_after", {28'd0, gnts(), mem_rd}, 32'd0);

    // Locked push pair by m1 while m0 waits
    m1_req = 1'b1; m1_wr = 1'b1; m1_lock = 1'b1; m1_addr = 8'hFE; m1_wdata = 8'h3F;
    m0_req = 1'b1; m0_addr = 8'h20; m0_wr = 1'b0;
    look();
    chk("push_idle", {28'd0, gnts(), mem_wr}, 32'd0);
    next(); look();
    chk("push1_wr", {31'd0, mem_wr}, 32'd1);
    chk("push1_addr_data", {16'd0, mem_addr, mem_wdata}, 32'hFE3F);
    chk("push1_gnt", {29'd0, gnts()}, 32'b010);
    next(); m1_addr = 8'hFD; m1_wdata = 8'h42; m1_lock = 1'b0; look();
    chk("push2_wr", {31'd0, mem_wr}, 32'd1);
    chk("push2_addr_data", {16'd0, mem_addr, mem_wdata}, 32'hFD42);
    chk("push2_gnt", {29'd0, gnts()}, 32'b010);
    next(); m1_req = 1'b0; look();
    chk("push_gap", {28'd0, gnts(), mem_rd}, 32'd0);
    next(); mem_rdata = 8'h5A; look();
    chk("push_m0_rd", {31'd0, mem_rd}, 32'd1);
    chk("push_m0_addr", {24'd0, mem_addr}, 32'h20);
    chk("push_m0_gnt", {29'd0, gnts()}, 32'b001);
    chk("push_m0_rdata", {24'd0, m0_rdata}, 32'h5A);
    next(); m0_req = 1'b0;

    // Reset restores rr_ptr so m0 is searched first
    rst_n = 1'b0;
    next(); rst_n = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m2_req = 1'b1; m1_wr = 1'b0; m2_wr = 1'b0;
    m0_addr = 8'h30; m1_addr = 8'h31; m2_addr = 8'h32;
    for (int k = 0; k < 10; k++) begin
      look();
      exp_g = (k % 2 == 1) ? (3'b001 << (((k - 1) / 2) % 3)) : 3'b000;
      chk($sformatf("rr_gnt_c%0d", k), {29'd0, gnts()}, {29'd0, exp_g});
      next();
    end
    m0_req = 1'b0; m1_req = 1'b0; m2_req = 1'b0;

    // Three wait states then ready
    look();
    m2_req = 1'b1; m2_addr = 8'h40; mem_ready = 1'b0; mem_rdata = 8'h77;
    for (int i = 1; i <= 3; i++) begin
      next(); look();
      chk($sformatf("ws_wait%0d", i), {27'd0, gnts(), bus_err, mem_rd}, 32'd1);
    end
    next(); mem_ready = 1'b1; look();
    chk("ws_gnt", {28'd0, gnts(), bus_err}, {28'd0, 3'b100, 1'b0});
    chk("ws_rdata", {24'd0, m2_rdata}, 32'h77);
    next(); mem_ready = 1'b0; look();
    chk("to_idle", {28'd0, gnts(), mem_rd}, 32'd0);

    // Timeout: memory never answers
    for (int i = 1; i <= 14; i++) begin
      next(); look();
      chk($sformatf("to_wait%0d", i), {27'd0, gnts(), bus_err, mem_rd}, 32'd1);
    end
    next(); look();
    chk("to_err_gnt", {28'd0, gnts(), bus_err}, {28'd0, 3'b100, 1'b1});
    chk("to_rdata", {24'd0, m2_rdata}, 32'hFF);
    chk("to_strobe_off", {31'd0, mem_rd}, 32'd0);
    next(); m2_req = 1'b0; look();
    chk("to_after", {28'd0, gnts(), bus_err}, 32'd0);

    // Withdrawal of m0 write mid-BUSY
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h50; m0_wdata = 8'h11;
    next(); look();
    chk("wd_busy_wr", {15'd0, mem_wr, mem_addr, mem_wdata}, {15'd0, 1'b1, 16'h5011});
    next(); m0_req = 1'b0; look();
    chk("wd_drop", {28'd0, gnts(), mem_wr}, 32'd0);
    next(); m0_req = 1'b1; look();
    chk("wd_idle_next", {31'd0, mem_wr}, 32'd0);
    next(); look();
    chk("wd_rebusy", {31'd0, mem_wr}, 32'd1);

    // Asynchronous reset mid-BUSY
    rst_n = 1'b0; #1;
    chk("arst_strobe", {30'd0, mem_wr, mem_rd}, 32'd0);
    chk("arst_addr_data", {16'd0, mem_addr, mem_wdata}, 32'd0);
    mem_ready = 1'b1; #1;
    chk("arst_gnt_err", {28'd0, gnts(), bus_err}, 32'd0);
    chk("arst_rdata", {24'd0, m0_rdata}, 32'd0);
    next(); m0_req = 1'b0; rst_n = 1'b1;
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Three-master arbiter in front of the MiniRISC data memory bus.
- Masters:
  - m0: CPU load/store datapath.
  - m1: stack push/pop engine for interrupt/call/return.
  - m2: debug/DMA port.
- Serialises their byte accesses onto one memory port and returns a per-master grant that marks access completion. The stack engine advances its state machine on that grant.
- Supports locked back-to-back sequences so multi-byte pushes/pops are not interleaved with other masters.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- TIMEOUT, 15, maximum BUSY cycles without mem_ready before error abort (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mX_req  input  1  access request, X=0..2; held with its qualifiers until mX_gnt.
- mX_wr  input  1  1=write, 0=read.
- mX_lock  input  1  keep bus ownership after this access while mX_req remains high.
- mX_addr  input  ADDR_W  byte address.
- mX_wdata  input  DATA_W  write data.
- mX_gnt  output  1  one-cycle pulse: access completed this cycle.
- mX_rdata  output  DATA_W  read data, valid only in the mX_gnt cycle.
- mem_addr  output  ADDR_W  memory address.
- mem_wr  output  1  write strobe.
- mem_rd  output  1  read strobe.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, sampled when mem_ready=1.
- mem_ready  input  1  memory completes the strobed access this cycle.
- bus_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, owner=none, rr_ptr=2 (so m0 searched first), timeout counter=0.
  - All mX_gnt=0, mem_wr=mem_rd=0, mem_addr=0, mem_wdata=0, bus_err=0, mX_rdata=0.
  - Reset mid-access aborts immediately; no grant is issued.
- States: IDLE, BUSY.
- IDLE:
  - No memory strobes.
  - If any mX_req=1, pick winner by round-robin starting at rr_ptr+1 (mod 3).
  - Register owner and go to BUSY; counter=0.
  - Minimum latency is request in cycle t, strobes in t+1.
- BUSY:
  - mem_addr/mem_wdata = owner's mX_addr/mX_wdata (combinational mux).
  - mem_wr = owner_req & owner_wr; mem_rd = owner_req & ~owner_wr.
- BUSY, owner_req=0 (withdrawn): strobes are already 0 this cycle; return to IDLE; no grant; rr_ptr unchanged.
- BUSY, mem_ready=1:
  - mX_gnt(owner)=1 combinationally that cycle; mX_rdata(owner)=mem_rdata passthrough. Non-owners' rdata are held at 0.
  - rr_ptr <= owner.
  - If owner's mX_lock=1: stay in BUSY with same owner, counter=0. The next access may start the following cycle with zero idle gap.
  - Otherwise go to IDLE.
- BUSY, mem_ready=0: counter++.
- Timeout: when counter reaches TIMEOUT-1 with mem_ready still 0:
  - bus_err=1 and mX_gnt(owner)=1 with mX_rdata(owner)={DATA_W{1'b1}}.
  - Strobes are deasserted that cycle; go to IDLE; lock ignored.
- Simultaneous events:
  - mem_ready and the timeout condition in the same cycle: mem_ready wins, no error.
  - Lock held by owner while other masters request: others wait indefinitely; lock release takes effect at the next grant.
- At most one mX_gnt is high in any cycle. Strobes are never asserted in IDLE.

Decomposition:
- Shared include arb_defs.vh: state encodings (ARB_IDLE=1'b0, ARB_BUSY=1'b1), master indices (M_CPU=2'd0, M_STACK=2'd1, M_DBG=2'd2), error read pattern.
- One sub-module, rr_pick3: combinational 3-way round-robin picker (inputs req[2:0], rr_ptr; outputs valid, idx).

Test Plan:
- Single read: m0 reads addr 8'h10, memory returns 8'hA5 with mem_ready in the first BUSY cycle. Required: mem_rd high in cycle t+1, m0_gnt pulse in t+1, m0_rdata=8'hA5, back in IDLE at t+2.
- Locked push pair: m1 writes 8'h3F to 8'hFE, then 8'h42 to 8'hFD with m1_lock=1 on the first access; m0 requests throughout. Required: the two m1 writes occur on consecutive cycles, and the m0 access follows only after the second m1_gnt.
- Round-robin fairness: all three masters request continuously, mem_ready=1, no locks. Required: grant order m0, m1, m2, m0…, each grant 2 cycles apart.
- Wait states and timeout:
  - mem_ready delayed 3 cycles: m2_gnt arrives in the 4th BUSY cycle, bus_err=0.
  - mem_ready never asserted (TIMEOUT=15): bus_err and m2_gnt pulse together in the 15th BUSY cycle, m2_rdata=8'hFF.
- Withdrawal and reset: m0 drops req during BUSY, which must give no grant, IDLE next cycle, and strobes 0. Asserting rst_n=0 mid-BUSY must clear all outputs asynchronously before the next clk edge.
